// File: rtl/program_memory.sv
// program_memory: loadable instruction store with a registered fetch
// port, a byte-serial loader and per-word valid bits.
module program_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH = 28,
  parameter int LOAD_WIDTH = 8,
  parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iFetch,
  input  logic [ADDR_WIDTH-1:0]  iAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oInstrValid,
  input  logic                   iLoadStart,
  input  logic [ADDR_WIDTH-1:0]  iLoadBase,
  input  logic [ADDR_WIDTH:0]    iLoadCount,
  input  logic                   iByteValid,
  input  logic [LOAD_WIDTH-1:0]  iByte,
  output logic                   oByteReady,
  input  logic                   iClear,
  output logic                   oBusy,
  output logic                   oLoadDone
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BYTES =
    (INSTR_WIDTH + LOAD_WIDTH - 1) / LOAD_WIDTH;
  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH + 1)'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH:0]    cnt;
  logic [BW-1:0]          beat;
  logic [INSTR_WIDTH-1:0] word;
  logic [DEPTH-1:0]       valid;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic idle;
  logic fetch_ok;
  logic clear_ok;
  logic start_ok;

  assign idle     = (state == IDLE);
  assign fetch_ok = idle & iFetch;
  assign clear_ok = idle & iClear;
  assign start_ok = idle & iLoadStart & ~iClear;

  assign oBusy      = ~idle;
  assign oByteReady = (state == RECV);
  assign oLoadDone  = (state == DONE);

  // Loader FSM: gathers beats MSB-first, one commit cycle per word.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      beat  <= '0;
      word  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            addr  <= iLoadBase;
            cnt   <= iLoadCount;
            beat  <= '0;
            state <= (iLoadCount != '0) ? RECV : DONE;
          end
        end
        RECV: begin
          if (iByteValid) begin
            // Truncation drops first-beat pad bits.
            word <= INSTR_WIDTH'({word, iByte});
            if (beat == LAST) begin
              beat  <= '0;
              state <= COMMIT;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        COMMIT: begin
          addr  <= addr + 1'b1;
          cnt   <= cnt - 1'b1;
          state <= (cnt > ONE) ? RECV : DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: set on commit, wiped by reset or an idle clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      valid <= '0;
    end else if (clear_ok) begin
      valid <= '0;
    end else if (state == COMMIT) begin
      valid[addr] <= 1'b1;
    end
  end

  // Storage array, kept reset-free so it maps onto block RAM.
  always_ff @(posedge Clock) begin
    if (state == COMMIT) begin
      mem[addr] <= word;
    end
  end

  // Registered fetch port; unwritten words read as the default.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oInstruction <= DEFAULT_INSTR;
      oInstrValid  <= 1'b0;
    end else begin
      oInstrValid <= fetch_ok;
      if (fetch_ok) begin
        oInstruction <= valid[iAddress] ? mem[iAddress]
                                        : DEFAULT_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: randomized loads and fetches checked through
// a fetch scoreboard against an array-based memory model.
module tb_program_memory;

  localparam int AW = 8;
  localparam int IW = 28;
  localparam int LW = 8;
  localparam int DEPTH = 256;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iFetch = 1'b0;
  logic [AW-1:0] iAddress = '0;
  logic [IW-1:0] oInstruction;
  logic          oInstrValid;
  logic          iLoadStart = 1'b0;
  logic [AW-1:0] iLoadBase = '0;
  logic [AW:0]   iLoadCount = '0;
  logic          iByteValid = 1'b0;
  logic [LW-1:0] iByte = '0;
  logic          oByteReady;
  logic          iClear = 1'b0;
  logic          oBusy;
  logic          oLoadDone;

  always #5 Clock = ~Clock;

  program_memory #(
    .ADDR_WIDTH(AW),
    .INSTR_WIDTH(IW),
    .LOAD_WIDTH(LW),
    .DEFAULT_INSTR(28'h0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iFetch(iFetch),
    .iAddress(iAddress),
    .oInstruction(oInstruction),
    .oInstrValid(oInstrValid),
    .iLoadStart(iLoadStart),
    .iLoadBase(iLoadBase),
    .iLoadCount(iLoadCount),
    .iByteValid(iByteValid),
    .iByte(iByte),
    .oByteReady(oByteReady),
    .iClear(iClear),
    .oBusy(oBusy),
    .oLoadDone(oLoadDone)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [IW-1:0] ref_mem [DEPTH];
  bit            ref_valid [DEPTH];
  logic [IW-1:0] exp_q [$];

  function automatic logic [IW-1:0] ref_read(int a);
    return ref_valid[a % DEPTH] ? ref_mem[a % DEPTH] : '0;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
  endtask

  // Scoreboard monitor: every cycle either a queued fetch result
  // is due, or no result may appear.
  always @(negedge Clock) begin
    if (Reset) begin
      if (exp_q.size() > 0) begin
        check("fetch_valid", {31'b0, oInstrValid}, 1);
        check("fetch_data", {4'b0, oInstruction},
              {4'b0, exp_q.pop_front()});
      end else begin
        check("no_fetch_valid", {31'b0, oInstrValid}, 0);
      end
    end
  end

  task automatic do_fetch(input int a, input bit clr);
    logic [IW-1:0] e;
    e = ref_read(a);
    iFetch = 1'b1;
    iAddress = AW'(a);
    iClear = clr;
    tick();
    iFetch = 1'b0;
    iClear = 1'b0;
    exp_q.push_back(e);
    if (clr) ref_clear();
  endtask

  task automatic do_load(input int base, input int count,
                         input logic [IW-1:0] wl [$],
                         input int gap_at, input int gap_len,
                         input bit poke);
    logic [LW-1:0] beats [$];
    logic [IW-1:0] words [$];
    logic [IW-1:0] v;
    logic [3:0]    pad;
    logic [31:0]   full;
    int idx;
    int gap;
    int cycles;
    int exp_cycles;
    idx = 0;
    gap = gap_len;
    for (int w = 0; w < count; w++) begin
      if (wl.size() > 0) begin
        v = wl[w];
        pad = 4'h0;
      end else begin
        v = IW'($urandom);
        pad = 4'($urandom);
      end
      words.push_back(v);
      full = {pad, v};
      for (int b = 3; b >= 0; b--) begin
        beats.push_back(full[b*8 +: 8]);
      end
    end
    iLoadBase = AW'(base);
    iLoadCount = (AW + 1)'(count);
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    check("busy_after_start", {31'b0, oBusy}, 1);
    if (count == 0) begin
      check("no_ready_count0", {31'b0, oByteReady}, 0);
    end
    cycles = 1;
    while (!oLoadDone && cycles < 5000) begin
      iFetch = poke;
      iAddress = AW'($urandom);
      if (poke && cycles == 3) begin
        iLoadStart = 1'b1;
        iLoadBase = AW'(base + 7);
        iLoadCount = 1;
      end else begin
        iLoadStart = 1'b0;
      end
      if (idx == gap_at && gap > 0) begin
        iByteValid = 1'b0;
        iByte = LW'($urandom);
        if (oByteReady) gap--;
      end else if (idx < beats.size()) begin
        iByteValid = 1'b1;
        iByte = beats[idx];
        if (oByteReady) idx++;
      end else begin
        iByteValid = 1'b0;
        iByte = LW'($urandom);
      end
      tick();
      cycles++;
    end
    iByteValid = 1'b0;
    iFetch = 1'b0;
    iLoadStart = 1'b0;
    exp_cycles = count * 5 + 1;
    if (gap_at < beats.size()) exp_cycles += gap_len;
    check("load_done_cycles", cycles, exp_cycles);
    check("beats_consumed", idx, beats.size());
    tick();
    check("busy_after_done", {31'b0, oBusy}, 0);
    for (int i = 0; i < count; i++) begin
      ref_mem[(base + i) % DEPTH] = words[i];
      ref_valid[(base + i) % DEPTH] = 1'b1;
    end
  endtask

  initial begin
    logic [IW-1:0] none [$];
    logic [IW-1:0] wl [$];
    ref_clear();
    tick();
    tick();
    check("rst_instr", {4'b0, oInstruction}, 0);
    check("rst_valid", {31'b0, oInstrValid}, 0);
    check("rst_busy", {31'b0, oBusy}, 0);
    check("rst_ready", {31'b0, oByteReady}, 0);
    check("rst_done", {31'b0, oLoadDone}, 0);
    Reset = 1'b1;
    tick();

    do_fetch(5, 0);

    wl.push_back(28'h0A12345);
    wl.push_back(28'hFFFFFFF);
    do_load(0, 2, wl, 1000, 0, 0);
    do_fetch(0, 0);
    do_fetch(1, 0);

    do_load(8'hFF, 2, none, 2, 3, 0);
    do_fetch(8'hFF, 0);
    do_fetch(0, 0);
    do_fetch(1, 0);

    do_load(8'h20, 0, none, 1000, 0, 0);
    do_fetch(8'h20, 0);
    do_load(8'h30, 2, none, 1000, 0, 1);
    do_fetch(8'h30, 0);
    do_fetch(8'h31, 0);
    do_fetch(8'h37, 0);

    iLoadBase = 8'h40;
    iLoadCount = 3;
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    for (int b = 0; b < 4; b++) begin
      iByteValid = 1'b1;
      iByte = LW'($urandom);
      tick();
    end
    iByteValid = 1'b0;
    tick();
    Reset = 1'b0;
    #2;
    check("async_rst_busy", {31'b0, oBusy}, 0);
    check("async_rst_instr", {4'b0, oInstruction}, 0);
    ref_clear();
    tick();
    Reset = 1'b1;
    tick();
    do_fetch(8'h40, 0);
    do_fetch(0, 0);
    do_load(8'h40, 3, none, 1000, 0, 0);
    do_fetch(8'h40, 0);
    do_fetch(8'h42, 0);

    do_load(3, 1, none, 1000, 0, 0);
    do_fetch(3, 0);
    do_fetch(3, 1);
    do_fetch(3, 0);

    do_load(3, 1, none, 1000, 0, 0);
    iClear = 1'b1;
    iLoadStart = 1'b1;
    iLoadBase = 8'h50;
    iLoadCount = 1;
    tick();
    iClear = 1'b0;
    iLoadStart = 1'b0;
    ref_clear();
    check("clear_beats_start", {31'b0, oBusy}, 0);
    do_fetch(3, 0);

    do_load(8'h10, 258, none, 1000, 0, 0);
    do_fetch(8'h10, 0);
    do_fetch(8'h11, 0);
    do_fetch(8'h12, 0);
    do_fetch(8'h0F, 0);

    repeat (25) begin
      int base;
      int cnt;
      base = $urandom_range(0, 255);
      cnt = ($urandom_range(0, 7) == 0) ? 0
                                        : $urandom_range(1, 4);
      do_load(base, cnt, none, $urandom_range(0, cnt * 4),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat (6) begin
        int a;
        if ($urandom_range(0, 1) == 1)
          a = (base + $urandom_range(0, 4)) % DEPTH;
        else
          a = $urandom_range(0, 255);
        do_fetch(a, $urandom_range(0, 15) == 0);
      end
    end

    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
